// File: rtl/sim_trap_monitor.sv
// End-of-test monitor: watches the commit stream for the ebreak trap and raises sticky finish/pass flags.
// Define SIM_WATCHDOG_EN to add a no-commit watchdog that ends a hung run with sim_timeout.
module sim_trap_monitor #(
  parameter int COMMIT_W   = 2,
  parameter int XLEN       = 32,
  parameter int CNT_W      = 64,
  parameter int WDOG_LIMIT = 4096
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [COMMIT_W-1:0]      commit_valid,
  input  logic [COMMIT_W*32-1:0]   commit_inst,
  input  logic [COMMIT_W*XLEN-1:0] commit_pc,
  input  logic [XLEN-1:0]          trap_a0,
  output logic                     sim_finish,
  output logic                     sim_pass,
  output logic                     sim_timeout,
  output logic [CNT_W-1:0]         cycle_cnt,
  output logic [CNT_W-1:0]         instr_cnt,
  output logic [XLEN-1:0]          trap_pc,
  output logic [XLEN-1:0]          trap_code
);

  localparam logic [31:0] EBREAK = 32'h00100073;
  localparam int POP_W = $clog2(COMMIT_W + 1);

  typedef enum logic {RUN, DONE} state_t;
  state_t state, state_nxt;

  logic [XLEN-1:0]  last_pc, last_pc_nxt;
  logic [CNT_W-1:0] cycle_nxt, instr_nxt;
  logic             finish_nxt, pass_nxt;
  logic [XLEN-1:0]  trap_pc_nxt, trap_code_nxt;

  logic             trap_hit;
  logic [POP_W-1:0] commit_num;
  logic [XLEN-1:0]  counted_pc, trap_slot_pc;

`ifdef SIM_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_LIMIT + 1);
  logic [WDOG_W-1:0] wdog_cnt, wdog_nxt;
  logic              timeout_nxt;
`endif

  // Slots are scanned oldest first; once the trap is seen, younger slots are dropped.
  always_comb begin
    trap_hit     = 1'b0;
    commit_num   = '0;
    counted_pc   = last_pc;
    trap_slot_pc = '0;
    for (int s = 0; s < COMMIT_W; s++) begin
      if (commit_valid[s] && !trap_hit) begin
        commit_num = commit_num + POP_W'(1);
        counted_pc = commit_pc[s*XLEN +: XLEN];
        if (commit_inst[s*32 +: 32] == EBREAK) begin
          trap_hit     = 1'b1;
          trap_slot_pc = commit_pc[s*XLEN +: XLEN];
        end
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    cycle_nxt     = cycle_cnt;
    instr_nxt     = instr_cnt;
    last_pc_nxt   = last_pc;
    finish_nxt    = sim_finish;
    pass_nxt      = sim_pass;
    trap_pc_nxt   = trap_pc;
    trap_code_nxt = trap_code;
`ifdef SIM_WATCHDOG_EN
    wdog_nxt      = wdog_cnt;
    timeout_nxt   = sim_timeout;
`endif
    case (state)
      RUN: begin
        cycle_nxt   = cycle_cnt + CNT_W'(1);
        instr_nxt   = instr_cnt + CNT_W'(commit_num);
        last_pc_nxt = counted_pc;
        if (trap_hit) begin
          finish_nxt    = 1'b1;
          pass_nxt      = (trap_a0 == '0);
          trap_pc_nxt   = trap_slot_pc;
          trap_code_nxt = trap_a0;
          state_nxt     = DONE;
        end
`ifdef SIM_WATCHDOG_EN
        if (commit_valid == '0) begin
          wdog_nxt = wdog_cnt + WDOG_W'(1);
          if (wdog_cnt == WDOG_W'(WDOG_LIMIT - 1)) begin
            finish_nxt    = 1'b1;
            timeout_nxt   = 1'b1;
            pass_nxt      = 1'b0;
            trap_pc_nxt   = last_pc;
            trap_code_nxt = '1;
            state_nxt     = DONE;
          end
        end else begin
          wdog_nxt = '0;
        end
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= RUN;
      cycle_cnt  <= '0;
      instr_cnt  <= '0;
      last_pc    <= '0;
      sim_finish <= 1'b0;
      sim_pass   <= 1'b0;
      trap_pc    <= '0;
      trap_code  <= '0;
    end else begin
      state      <= state_nxt;
      cycle_cnt  <= cycle_nxt;
      instr_cnt  <= instr_nxt;
      last_pc    <= last_pc_nxt;
      sim_finish <= finish_nxt;
      sim_pass   <= pass_nxt;
      trap_pc    <= trap_pc_nxt;
      trap_code  <= trap_code_nxt;
    end
  end

`ifdef SIM_WATCHDOG_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      wdog_cnt    <= '0;
      sim_timeout <= 1'b0;
    end else begin
      wdog_cnt    <= wdog_nxt;
      sim_timeout <= timeout_nxt;
    end
  end
`else
  assign sim_timeout = 1'b0;
`endif

endmodule
